// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, decade limits and a validity check.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t nibble);
    return nibble <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: combinational next value with ripple carry/borrow out and
// sanitised parallel load.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] cur,
  input  logic       step_in,
  input  logic       up_down,
  input  logic       load,
  input  logic [3:0] load_nib,
  output logic [3:0] nxt,
  output logic       step_out,
  output logic       nib_err
);

  // Load dominates; an out-of-range nibble is replaced by zero so the count
  // can never hold a non-decimal digit.
  always_comb begin
    nxt      = cur;
    step_out = 1'b0;
    nib_err  = 1'b0;
    if (load) begin
      nib_err = !bcd_valid(load_nib);
      nxt     = nib_err ? BCD_MIN : load_nib;
    end else if (step_in) begin
      if (up_down) begin
        if (cur == BCD_MAX) begin
          nxt      = BCD_MIN;
          step_out = 1'b1;
        end else begin
          nxt = cur + 4'd1;
        end
      end else begin
        if (cur == BCD_MIN) begin
          nxt      = BCD_MAX;
          step_out = 1'b1;
        end else begin
          nxt = cur - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// Multi-decade BCD up/down counter with load, enable, wrap/saturate mode,
// combinational terminal count and a one-cycle load-error flag.
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up_down,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

  logic [DIGITS:0]   step;
  logic [W-1:0]      count_nxt;
  logic [DIGITS-1:0] nib_err;

  assign step[0] = en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .cur      (count[4*i +: 4]),
      .step_in  (step[i]),
      .up_down  (up_down),
      .load     (load),
      .load_nib (load_val[4*i +: 4]),
      .nxt      (count_nxt[4*i +: 4]),
      .step_out (step[i+1]),
      .nib_err  (nib_err[i])
    );
  end

  assign tc = en & ((up_down & (count == ALL_NINES)) | (~up_down & (count == '0)));

  // A carry/borrow out of the top decade marks a step at the terminal value;
  // in saturate mode that step is suppressed so the count holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= |nib_err;
      if (!(SATURATE && step[DIGITS]))
        count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Self-checking bench: wrap and saturate counters against a decimal model,
// plus a two-instance cascade counted through a full wrap.
module tb_bcd_updown_counter_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        up_down;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count0, count1;
  logic        tc0, tc1, err0, err1;

  logic        casc_en;
  logic [7:0]  lo_count, hi_count;
  logic        lo_tc, hi_tc, lo_err, hi_err;

  int tests = 0;
  int fails = 0;
  int exp0, exp1, casc_v;
  bit exp_err;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .count(count0), .tc(tc0), .load_err(err0)
  );

  bcd_updown_counter_n #(.DIGITS(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .count(count1), .tc(tc1), .load_err(err1)
  );

  bcd_updown_counter_n #(.DIGITS(2), .SATURATE(1'b0)) casc_lo (
    .clk(clk), .reset(reset), .en(casc_en), .up_down(1'b1), .load(1'b0),
    .load_val(8'h00), .count(lo_count), .tc(lo_tc), .load_err(lo_err)
  );

  bcd_updown_counter_n #(.DIGITS(2), .SATURATE(1'b0)) casc_hi (
    .clk(clk), .reset(reset), .en(lo_tc), .up_down(1'b1), .load(1'b0),
    .load_val(8'h00), .count(hi_count), .tc(hi_tc), .load_err(hi_err)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int v;
    int d;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 0;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic bit has_bad(input logic [15:0] lv);
    bit b;
    b = 1'b0;
    for (int i = 0; i < 4; i++)
      if (lv[4*i +: 4] > 4'd9) b = 1'b1;
    return b;
  endfunction

  function automatic int step_val(input int v, input bit up, input bit sat);
    if (up) begin
      if (v == 9999) return sat ? 9999 : 0;
      return v + 1;
    end
    if (v == 0) return sat ? 0 : 9999;
    return v - 1;
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic apply_stimulus(input bit ld, input logic [15:0] lv, input bit e, input bit ud,
                                input string tag);
    load = ld; load_val = lv; en = e; up_down = ud;
    #1;
    check_bit({tag, "/tc_wrap"}, tc0, e && ((ud && exp0 == 9999) || (!ud && exp0 == 0)));
    check_bit({tag, "/tc_sat"},  tc1, e && ((ud && exp1 == 9999) || (!ud && exp1 == 0)));
    @(posedge clk);
    if (ld) begin
      exp0    = from_load(lv);
      exp1    = exp0;
      exp_err = has_bad(lv);
    end else begin
      exp_err = 1'b0;
      if (e) begin
        exp0 = step_val(exp0, ud, 1'b0);
        exp1 = step_val(exp1, ud, 1'b1);
      end
    end
    #1;
    check_output({tag, "/count_wrap"}, count0, to_bcd(exp0));
    check_output({tag, "/count_sat"},  count1, to_bcd(exp1));
    check_bit({tag, "/err_wrap"}, err0, exp_err);
    check_bit({tag, "/err_sat"},  err1, exp_err);
    check_bit({tag, "/digits_wrap"}, has_bad(count0), 1'b0);
    check_bit({tag, "/digits_sat"},  has_bad(count1), 1'b0);
  endtask

  task automatic mid_reset(input string tag);
    load = 1'b0; en = 1'b0;
    #3 reset = 1'b0;
    #1;
    exp0 = 0; exp1 = 0; exp_err = 1'b0;
    check_output({tag, "/async_count"}, count0, 16'h0000);
    check_output({tag, "/async_count_sat"}, count1, 16'h0000);
    check_bit({tag, "/async_err"}, err0, 1'b0);
    check_bit({tag, "/async_err_sat"}, err1, 1'b0);
    @(posedge clk);
    #1;
    check_output({tag, "/held_count"}, count0, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit          r_ld, r_en, r_ud;
    logic [15:0] r_lv;

    reset = 1'b0; en = 1'b0; up_down = 1'b1; load = 1'b0; load_val = '0; casc_en = 1'b0;
    exp0 = 0; exp1 = 0; exp_err = 1'b0; casc_v = 0;
    #12;
    check_output("reset/count", count0, 16'h0000);
    check_bit("reset/err", err0, 1'b0);
    check_output("reset/casc", {hi_count, lo_count}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset in the middle of a count, then resume
    apply_stimulus(1'b1, 16'h0455, 1'b0, 1'b1, "t1_load");
    apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1, "t1_up_a");
    apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1, "t1_up_b");
    check_output("t1/at_0457", count0, 16'h0457);
    mid_reset("t1");
    apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1, "t1_resume");

    // Multi-decade carry
    apply_stimulus(1'b1, 16'h0999, 1'b1, 1'b1, "t2_load");
    apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1, "t2_up_a");
    apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1, "t2_up_b");

    // Terminal values: wrap vs saturate, both directions
    apply_stimulus(1'b1, 16'h9999, 1'b0, 1'b1, "t3_load9999");
    apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1, "t3_up_term");
    apply_stimulus(1'b1, 16'h0000, 1'b0, 1'b0, "t3_load0");
    apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0, "t3_down_term");
    apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1, "t3_up_after");

    // Borrow chain and enable hold
    apply_stimulus(1'b1, 16'h1000, 1'b0, 1'b0, "t4_load");
    apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0, "t4_down_a");
    apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b0, "t4_down_b");
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, "t4_hold_a");
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, "t4_hold_b");
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, "t4_hold_c");

    // Invalid-nibble load, load priority over enable, reset clears the error flag
    apply_stimulus(1'b1, 16'h3A7F, 1'b1, 1'b1, "t5_load_bad");
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, "t5_err_clear");
    apply_stimulus(1'b1, 16'hFFFF, 1'b0, 1'b1, "t5_load_ffff");
    mid_reset("t5");

    // Randomised traffic
    for (int n = 0; n < 500; n++) begin
      r_ld = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       r_lv = 16'h9999;
        1:       r_lv = 16'h0000;
        2:       r_lv = 16'($urandom);
        default: r_lv = to_bcd(int'($urandom_range(0, 9999)));
      endcase
      r_en = ($urandom_range(0, 3) != 0);
      r_ud = 1'($urandom_range(0, 1));
      apply_stimulus(r_ld, r_lv, r_en, r_ud, "rand");
    end

    // Cascade of two 2-digit instances through a full wrap
    load = 1'b0; en = 1'b0;
    check_output("casc/idle", {hi_count, lo_count}, 16'h0000);
    @(negedge clk);
    casc_en = 1'b1;
    for (int n = 0; n < 10001; n++) begin
      @(posedge clk);
      #1;
      casc_v = (casc_v + 1) % 10000;
      check_output("casc/value", {hi_count, lo_count}, to_bcd(casc_v));
      check_bit("casc/digits", has_bad({hi_count, lo_count}), 1'b0);
      check_bit("casc/lo_tc", lo_tc, (casc_v % 100) == 99);
      check_bit("casc/hi_tc", hi_tc, casc_v == 9999);
    end
    casc_en = 1'b0;
    check_bit("casc/no_err", lo_err | hi_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
